// File: rtl/bitloop_seq.sv
// ============================================================================
// Module      : bitloop_seq
// Description : Two-phase bit loop. LOW copies snap[idx] into res, then HIGH
//               writes snap[idx] & snap[NBITS+idx]; one bit per clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bitloop_seq #(
    parameter int NBITS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         clr,
    input  logic [127:0] in,
    output logic         busy,
    output logic         done,
    output logic [127:0] out
);

    localparam int                c_w    = 2 * NBITS;
    localparam int                c_iw   = $clog2(NBITS) + 1;
    localparam logic [c_iw-1:0]   c_last = c_iw'(NBITS - 1);

    localparam logic [1:0] c_s_idle = 2'd0;
    localparam logic [1:0] c_s_low  = 2'd1;
    localparam logic [1:0] c_s_high = 2'd2;

    logic [1:0]      r_state;
    logic [c_iw-1:0] r_idx;
    logic [c_w-1:0]  r_snap;
    logic [c_w-1:0]  r_res;
    logic [c_w-1:0]  r_out;
    logic            r_done;

    logic [1:0]      w_state_nxt;
    logic [c_iw-1:0] w_idx_nxt;
    logic [c_w-1:0]  w_snap_nxt;
    logic [c_w-1:0]  w_res_nxt;
    logic [c_w-1:0]  w_out_nxt;
    logic            w_done_nxt;
    logic [c_iw-1:0] w_hidx;

    // idx never exceeds NBITS-1, so NBITS+idx fits in c_iw bits.
    assign w_hidx = r_idx + c_iw'(NBITS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_s_idle;
            r_idx   <= '0;
            r_snap  <= '0;
            r_res   <= '0;
            r_out   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_snap  <= w_snap_nxt;
            r_res   <= w_res_nxt;
            r_out   <= w_out_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_snap_nxt  = r_snap;
        w_res_nxt   = r_res;
        w_out_nxt   = r_out;
        w_done_nxt  = 1'b0;
        case (r_state)
            c_s_idle: begin
                if (start && !clr) begin
                    w_snap_nxt  = in[c_w-1:0];
                    w_res_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = c_s_low;
                end
            end
            c_s_low: begin
                if (clr) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = c_s_idle;
                end else begin
                    w_res_nxt[r_idx] = r_snap[r_idx];
                    if (r_idx == c_last) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = c_s_high;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            c_s_high: begin
                if (clr) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = c_s_idle;
                end else begin
                    w_res_nxt[w_hidx] = r_snap[r_idx] & r_snap[w_hidx];
                    if (r_idx == c_last) begin
                        w_out_nxt   = w_res_nxt;
                        w_done_nxt  = 1'b1;
                        w_idx_nxt   = '0;
                        w_state_nxt = c_s_idle;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_idx_nxt   = '0;
                w_state_nxt = c_s_idle;
            end
        endcase
    end

    assign busy = (r_state != c_s_idle);
    assign done = r_done;
    assign out  = 128'(r_out);

    // Operand bits above 2*NBITS are never used by the loop.
    generate
        if (c_w < 128) begin : g_unused_in
            logic w_unused_in;
            assign w_unused_in = ^in[127:c_w];
        end
    endgenerate

endmodule

`default_nettype wire
